piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the four-stage serial shift register; drives that register's serial input.
- Accepts a WIDTH-bit word via valid/ready handshake and emits it MSB-first, one bit per clk rising edge.
- Provides framing strobes (shift_en, last, done) so downstream logic knows when the shift register holds a complete word.

Parameters:
- WIDTH, 4, word length in bits; default matches the four-stage downstream register; legal range 2..16.
- GAP, 1, idle cycles forced between words, with Out=0 and shift_en=0; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  parallel word; sampled only on handshake.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  block can accept a word this cycle.
- Out  output  1  serial bit; connects to downstream In.
- shift_en  output  1  Out carries a valid data bit this cycle.
- last  output  1  Out carries the final (LSB) bit of the word.
- busy  output  1  high in SHIFT or GAP.
- done  output  1  one-cycle pulse in the cycle after the last bit.

Behaviour:
- All outputs are registered, except load_ready, which decodes from state.
- While nReset=0: state=IDLE, bit counter=0, shift register=0, Out=0, shift_en=0, last=0, busy=0, done=0, load_ready=1. Reset clears these immediately, without waiting for clk.
- Reset asserted mid-word aborts the word and discards it; no done pulse. The first handshake is possible on the first rising edge after nReset deasserts.
- Handshake: a word is accepted on a rising edge where load_valid=1 and load_ready=1. load_valid while load_ready=0 is ignored and the word is not captured. data_in changes after acceptance have no effect.
- FSM states: IDLE, SHIFT, GAP.
- IDLE: load_ready=1. On accept -> SHIFT, shift register <= data_in, counter <= 0.
- SHIFT:
  - Out = shreg[WIDTH-1] and shift_en=1. Shift left by one each edge and increment the counter.
  - last=1 when counter == WIDTH-1.
  - After the last bit: go to GAP if GAP>0, else to IDLE.
  - Back-to-back streaming when GAP==0: load_ready=1 during the last-bit cycle. An accept there goes straight to SHIFT with the new word, with no bubble.
  - load_ready=0 in all other SHIFT cycles.
- GAP: hold for exactly GAP cycles with Out=0, shift_en=0, load_ready=0, then go to IDLE.
- Latency and timing:
  - First data bit appears on Out in the cycle after the accepting edge.
  - The word occupies exactly WIDTH consecutive cycles.
  - done=1 in the cycle immediately after last=1, for exactly one cycle. With GAP==0 and back-to-back, done coincides with the first bit of the next word.
  - Word period: WIDTH+GAP cycles minimum.
- Downstream alignment: with WIDTH=4, in the cycle where done=1, the downstream register holds Q4,Q3,Q2,Q1 = data_in[3],[2],[1],[0].
- Out is forced to 0 whenever shift_en=0. The downstream register has no enable, so it shifts in zeros while this block is idle.
- Counter width: clog2(WIDTH); it wraps to 0 at word end and never exceeds WIDTH-1.

Test Plan:
1. Reset: hold nReset=0 and toggle clk -> Out=0, shift_en=0, busy=0, done=0, load_ready=1. Release, then wait 3 cycles -> outputs unchanged.
2. Single word: WIDTH=4, GAP=1, data_in=4'b1011 accepted at edge 0.
   - Out = 1,0,1,1 in cycles 1-4 with shift_en=1; last=1 only in cycle 4.
   - done=1 in cycle 5, load_ready=1 again in cycle 6.
   - Downstream Q4..Q1 = 1,0,1,1 in cycle 5.
3. Back-to-back: GAP=0 with load_valid held high, words 4'hA then 4'h5.
   - Out = 1,0,1,0,0,1,0,1 over 8 consecutive cycles with no bubble; load_ready high only in cycle 4 (A's last bit) until B's last.
   - done in cycle 5 (concurrent with B's first bit) and cycle 9.
4. Ignored load: while busy, pulse load_valid with data_in=4'hF -> no capture; the in-flight word 4'h3 is emitted intact as 0,0,1,1.
5. Mid-word reset: accept 4'hC and assert nReset low after the 2nd bit -> Out=0 and busy=0 immediately, no done pulse. After release, 4'h6 is accepted -> Out = 0,1,1,0.
6. Input hold: change data_in every cycle after accepting 4'h9 -> Out = 1,0,0,1 regardless.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out stage, MSB-first, valid/ready load,
// framing strobes (shift_en, last, done) and an optional idle gap between words.
`default_nettype none

module piso_serializer #(
   parameter int WIDTH = 4,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             nReset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             Out,
   output logic             shift_en,
   output logic             last,
   output logic             busy,
   output logic             done
);

   localparam int                c_CW       = $clog2(WIDTH);
   localparam logic [c_CW-1:0]   c_CNT_LAST = c_CW'(WIDTH - 1);
   localparam logic [c_CW-1:0]   c_CNT_PEN  = c_CW'(WIDTH - 2);
   localparam logic [3:0]        c_GAP_LAST = 4'(GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           r_state;
   // The MSB goes straight into r_out at load, so only the remaining bits are kept here.
   logic [WIDTH-2:0] r_shreg;
   logic [c_CW-1:0]  r_cnt;
   logic [3:0]       r_gcnt;
   logic             r_out;
   logic             r_shift_en;
   logic             r_last;
   logic             r_busy;
   logic             r_done;

   logic             w_last_bit;
   logic             w_accept;

   assign w_last_bit = (r_state == S_SHIFT) && (r_cnt == c_CNT_LAST);
   // With no gap, the last-bit cycle can accept the next word for gapless streaming.
   assign load_ready = (r_state == S_IDLE) || ((GAP == 0) && w_last_bit);
   assign w_accept   = load_valid && load_ready;

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_state    <= S_IDLE;
         r_shreg    <= '0;
         r_cnt      <= '0;
         r_gcnt     <= '0;
         r_out      <= 1'b0;
         r_shift_en <= 1'b0;
         r_last     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_last_bit;
         if (w_accept) begin
            r_state    <= S_SHIFT;
            r_shreg    <= data_in[WIDTH-2:0];
            r_out      <= data_in[WIDTH-1];
            r_cnt      <= '0;
            r_gcnt     <= '0;
            r_shift_en <= 1'b1;
            r_last     <= 1'b0;
            r_busy     <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_out      <= 1'b0;
                  r_shift_en <= 1'b0;
                  r_last     <= 1'b0;
                  r_busy     <= 1'b0;
               end
               S_SHIFT: begin
                  if (w_last_bit) begin
                     r_cnt      <= '0;
                     r_gcnt     <= '0;
                     r_out      <= 1'b0;
                     r_shift_en <= 1'b0;
                     r_last     <= 1'b0;
                     if (GAP > 0) begin
                        r_state <= S_GAP;
                        r_busy  <= 1'b1;
                     end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_shreg <= r_shreg << 1;
                     r_out   <= r_shreg[WIDTH-2];
                     r_cnt   <= r_cnt + 1'b1;
                     r_last  <= (r_cnt == c_CNT_PEN);
                  end
               end
               S_GAP: begin
                  if (r_gcnt == c_GAP_LAST) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_gcnt <= r_gcnt + 1'b1;
                  end
               end
               default: begin
                  r_state    <= S_IDLE;
                  r_out      <= 1'b0;
                  r_shift_en <= 1'b0;
                  r_last     <= 1'b0;
                  r_busy     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign Out      = r_out;
   assign shift_en = r_shift_en;
   assign last     = r_last;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

`default_nettype wire
